vde_bump_queue: RTL
===================

// Module: vde_bump_queue
// PURPOSE
//  Buffers variable-activity bump requests from conflict analysis (one learned-clause literal per cycle).
//  Packs them into multi-bump commands for vde_heap; forwards when the heap is idle.
//  Issues a heap decay pulse after every DECAY_PERIOD conflicts, once all earlier bumps have drained.
//  Sits between conflict analysis (upstream) and vde_heap (downstream).
// PARAMETERS
//  MAX_VARS      16  highest legal variable index (vars 1..MAX_VARS)
//  VAR_W         32  variable index width
//  DEPTH         16  FIFO entries, power of 2, >= PACK
//  PACK           8  max vars per heap multi-bump command
//  DECAY_PERIOD   4  conflicts per decay pulse, >= 1
// PORTS
//  clk            in   1             clock
//  reset          in   1             async reset, ACTIVE-LOW
//  flush          in   1             sync clear of all queue state (pairs with heap clear_all)
//  in_valid       in   1             bump request valid
//  in_var         in   VAR_W         variable to bump
//  in_ready       out  1             request accepted when in_valid & in_ready
//  conflict_done  in   1             one-cycle pulse: last literal of current learned clause sent
//  heap_busy      in   1             vde_heap busy
//  bump_count     out  4             vars in current command, 0 = no command
//  bump_vars      out  PACK x VAR_W  packed vars, lane 0 first
//  decay          out  1             one-cycle decay pulse to heap
//  pending        out  clog2(DEPTH)+1  FIFO occupancy
//  bad_var        out  1             sticky: an out-of-range var was dropped
//  idle           out  1             FIFO empty, no decay pending, FSM in IDLE
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, conflict counter 0, decay_pending 0, FSM IDLE.
//   Output values: bump_count=0, bump_vars=0, decay=0, bad_var=0, pending=0, in_ready=1, idle=1.
//  Accept: in_ready = !full & !decay_pending (registered). An accepted var is enqueued at the clock edge.
//   Var 0 or var > MAX_VARS: accepted, dropped, bad_var set.
//  Push and pop in the same cycle are legal; pending reflects both changes on the next cycle.
//  conflict_done: counter++. When counter == DECAY_PERIOD-1 the counter wraps to 0 and decay_pending is set.
//   conflict_done while decay_pending is already set: counter still increments, no second decay is queued.
//  FSM states IDLE, ISSUE, GUARD, WAIT:
//   IDLE->ISSUE: heap_busy=0 and pending>0. Pops n=min(pending,PACK) entries.
//     Lanes 0..n-1 carry the vars in FIFO order; lanes n..PACK-1 are 0. bump_count=n.
//   IDLE->ISSUE (decay): heap_busy=0, pending=0, decay_pending=1. Drives decay=1 and clears decay_pending.
//   ISSUE: outputs valid exactly 1 cycle, then cleared to 0. Goes to GUARD.
//   GUARD: 2 cycles, covering heap busy-assert latency, then WAIT.
//   WAIT: stays until heap_busy=0, then IDLE.
//  Latency: a var pushed into an empty queue with heap idle appears on bump_vars 2 cycles after acceptance.
//  Ordering: every bump accepted before the conflict_done that triggers a decay reaches the heap before that decay.
//  flush: has priority over all inputs. Empties FIFO and clears counter and decay_pending.
//   FSM goes to GUARD if in ISSUE/GUARD/WAIT, else IDLE.
//   in_valid in the flush cycle is dropped. bad_var is not cleared (reset only).
// CONFIGURATION
//  DEDUP_EN defined: a (MAX_VARS+1)-bit pending bitmap is kept.
//   Bit set on enqueue, cleared on pop, all cleared on flush/reset.
//   A var whose bit is set is accepted and discarded, and pending is unchanged.
//   A push and a pop of the same var in the same cycle leave the bit set and enqueue the var.
//  DEDUP_EN undefined: no bitmap; every legal accepted var is enqueued, duplicates included.
// TESTING
//  T1 single: heap idle, push var 5 -> 2 cycles later bump_count=1, bump_vars[0]=5 for 1 cycle; idle=1 afterwards.
//  T2 pack: hold heap_busy=1, push vars 1..10, release -> cmd1 count=8 vars 1..8, then after heap idle cmd2 count=2 vars 9,10, other lanes 0.
//  T3 full: heap_busy=1, push 16 vars -> in_ready=0 and pending=16; a 17th in_valid is not accepted; one pop re-raises in_ready.
//  T4 decay: DECAY_PERIOD=4, 4 conflicts each with 3 vars, heap toggling busy -> decay pulses once, after the last bump command; in_ready=0 while decay_pending.
//  T5 edge: push var 0 and var 17 -> not enqueued, bad_var=1; flush mid-WAIT with pending=5 -> pending=0 next cycle, no further commands; async reset mid-ISSUE -> bump_count=0 immediately.
//  T6 DEDUP_EN: heap busy, push 3,3,4,3 -> pending=2; commands carry 3,4 only. Without the macro -> pending=4.

Source files
------------

// File: rtl/vde_bump_queue.sv
// vde_bump_queue: buffers variable-activity bump requests, packs them into multi-bump
// heap commands and sequences periodic decay pulses. Optional macro DEDUP_EN drops queued duplicates.
module vde_bump_queue #(
  parameter int MAX_VARS     = 16,
  parameter int VAR_W        = 32,
  parameter int DEPTH        = 16,
  parameter int PACK         = 8,
  parameter int DECAY_PERIOD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [VAR_W-1:0]           in_var,
  output logic                       in_ready,
  input  logic                       conflict_done,
  input  logic                       heap_busy,
  output logic [3:0]                 bump_count,
  output logic [PACK-1:0][VAR_W-1:0] bump_vars,
  output logic                       decay,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       bad_var,
  output logic                       idle
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(MAX_VARS + 1);
  localparam int DC_W  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CNT_W-1:0] PACK_C  = CNT_W'(PACK);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DECAY_PERIOD - 1);
  localparam logic [VAR_W-1:0] MAX_C   = VAR_W'(MAX_VARS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t                     state_r, state_nx_s;
  logic [IDX_W-1:0]           mem_r [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]           count_r, count_nx_s, pop_n_s;
  logic [DC_W-1:0]            dcnt_r, dcnt_nx_s;
  logic                       decay_pend_r, decay_pend_nx_s;
  logic                       guard_r, guard_nx_s;
  logic                       in_ready_r, idle_r, decay_r, bad_var_r;
  logic [3:0]                 bump_count_r;
  logic [PACK-1:0][VAR_W-1:0] bump_vars_r, lanes_s;
  logic                       start_bump_s, start_decay_s;
  logic                       legal_s, accept_s, dup_s, enq_s;
  logic [IDX_W-1:0]           in_idx_s;

  assign in_idx_s = in_var[IDX_W-1:0];
  assign legal_s  = (in_var != '0) && (in_var <= MAX_C);
  assign accept_s = in_valid && in_ready_r && !flush;
  assign enq_s    = accept_s && legal_s && !dup_s;

  // Issue decision: bumps drain before any decay; lanes past pop_n read as zero
  always_comb begin
    start_bump_s  = 1'b0;
    start_decay_s = 1'b0;
    pop_n_s       = '0;
    if (!flush && (state_r == ST_IDLE) && !heap_busy) begin
      if (count_r != '0) begin
        start_bump_s = 1'b1;
        pop_n_s      = (count_r > PACK_C) ? PACK_C : count_r;
      end else begin
        start_decay_s = decay_pend_r;
      end
    end else begin
      start_bump_s = 1'b0;
    end
    for (int i = 0; i < PACK; i++) begin
      lanes_s[i] = (CNT_W'(i) < pop_n_s) ? VAR_W'(mem_r[rd_ptr_r + PTR_W'(i)]) : '0;
    end
  end

`ifdef DEDUP_EN
  localparam int BM_W = MAX_VARS + 1;
  logic [BM_W-1:0] bitmap_r, pop_mask_s;

  // A var leaving the queue this cycle may be enqueued again in the same cycle
  always_comb begin
    pop_mask_s = '0;
    for (int i = 0; i < PACK; i++) begin
      pop_mask_s[mem_r[rd_ptr_r + PTR_W'(i)]] = pop_mask_s[mem_r[rd_ptr_r + PTR_W'(i)]]
                                                | (CNT_W'(i) < pop_n_s);
    end
    dup_s = legal_s && bitmap_r[in_idx_s] && !pop_mask_s[in_idx_s];
  end

  // Queued-var bitmap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitmap_r <= '0;
    end else if (flush) begin
      bitmap_r <= '0;
    end else begin
      bitmap_r <= (bitmap_r & ~pop_mask_s) | (enq_s ? (BM_W'(1) << in_idx_s) : '0);
    end
  end
`else
  assign dup_s = 1'b0;
`endif

  // Next-state for occupancy, decay bookkeeping and the issue FSM
  always_comb begin
    count_nx_s      = count_r;
    dcnt_nx_s       = dcnt_r;
    decay_pend_nx_s = decay_pend_r;
    state_nx_s      = state_r;
    guard_nx_s      = guard_r;
    if (flush) begin
      count_nx_s      = '0;
      dcnt_nx_s       = '0;
      decay_pend_nx_s = 1'b0;
      state_nx_s      = (state_r == ST_IDLE) ? ST_IDLE : ST_GUARD;
      guard_nx_s      = 1'b0;
    end else begin
      count_nx_s      = count_r + CNT_W'(enq_s) - pop_n_s;
      decay_pend_nx_s = decay_pend_r && !start_decay_s;
      if (conflict_done) begin
        if (dcnt_r == DC_LAST) begin
          dcnt_nx_s       = '0;
          decay_pend_nx_s = 1'b1;
        end else begin
          dcnt_nx_s = dcnt_r + DC_W'(1);
        end
      end else begin
        dcnt_nx_s = dcnt_r;
      end
      case (state_r)
        ST_IDLE:  state_nx_s = (start_bump_s || start_decay_s) ? ST_ISSUE : ST_IDLE;
        ST_ISSUE: begin
          state_nx_s = ST_GUARD;
          guard_nx_s = 1'b0;
        end
        ST_GUARD: begin
          state_nx_s = guard_r ? ST_WAIT : ST_GUARD;
          guard_nx_s = !guard_r;
        end
        ST_WAIT:  state_nx_s = heap_busy ? ST_WAIT : ST_IDLE;
        default:  state_nx_s = ST_IDLE;
      endcase
    end
  end

  // FIFO storage needs no reset: only entries below the occupancy are ever read
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_r[wr_ptr_r] <= in_idx_s;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      guard_r      <= 1'b0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      dcnt_r       <= '0;
      decay_pend_r <= 1'b0;
      in_ready_r   <= 1'b1;
      idle_r       <= 1'b1;
      decay_r      <= 1'b0;
      bad_var_r    <= 1'b0;
      bump_count_r <= 4'd0;
      bump_vars_r  <= '0;
    end else begin
      state_r      <= state_nx_s;
      guard_r      <= guard_nx_s;
      count_r      <= count_nx_s;
      dcnt_r       <= dcnt_nx_s;
      decay_pend_r <= decay_pend_nx_s;
      in_ready_r   <= (count_nx_s != DEPTH_C) && !decay_pend_nx_s;
      idle_r       <= (count_nx_s == '0) && !decay_pend_nx_s && (state_nx_s == ST_IDLE);
      decay_r      <= start_decay_s;
      bad_var_r    <= bad_var_r || (accept_s && !legal_s);
      bump_count_r <= 4'(pop_n_s);
      bump_vars_r  <= lanes_s;
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(enq_s);
        rd_ptr_r <= rd_ptr_r + PTR_W'(pop_n_s);
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign idle       = idle_r;
  assign decay      = decay_r;
  assign bad_var    = bad_var_r;
  assign pending    = count_r;
  assign bump_count = bump_count_r;
  assign bump_vars  = bump_vars_r;
endmodule
